// File: rtl/register_bank.sv
// rtl/register_bank.sv - 16-entry register bank with single-port write and sequential clear
module register_bank #(
   parameter int              WIDTH       = 16,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             write_en,
   input  logic [3:0]       write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic             clear_req,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic [WIDTH-1:0] data_out2,
   output logic [WIDTH-1:0] data_out3,
   output logic [WIDTH-1:0] data_out4,
   output logic [WIDTH-1:0] data_out5,
   output logic [WIDTH-1:0] data_out6,
   output logic [WIDTH-1:0] data_out7,
   output logic [WIDTH-1:0] data_out8,
   output logic [WIDTH-1:0] data_out9,
   output logic [WIDTH-1:0] data_out10,
   output logic [WIDTH-1:0] data_out11,
   output logic [WIDTH-1:0] data_out12,
   output logic [WIDTH-1:0] data_out13,
   output logic [WIDTH-1:0] data_out14,
   output logic [WIDTH-1:0] data_out15,
   output logic             busy,
   output logic             write_drop
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state, state_next;
   logic [3:0]       clr_idx, clr_idx_next;
   logic [WIDTH-1:0] regs [16];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         clr_idx    <= 4'd0;
         write_drop <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= CLEAR_VALUE;
      end else begin
         state      <= state_next;
         clr_idx    <= clr_idx_next;
         write_drop <= (state == CLEAR) && write_en;
         // Writes are only honoured in IDLE; the clear walk owns the bank otherwise
         for (int i = 0; i < 16; i++) begin
            if (state == IDLE && write_en && write_addr == 4'(i))
               regs[i] <= write_data;
            else if (state == CLEAR && clr_idx == 4'(i))
               regs[i] <= CLEAR_VALUE;
         end
      end
   end

   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      unique case (state)
         IDLE: begin
            if (clear_req) begin
               state_next   = CLEAR;
               clr_idx_next = 4'd0;
            end
         end
         CLEAR: begin
            clr_idx_next = clr_idx + 4'd1;
            if (clr_idx == 4'd15) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy       = (state == CLEAR);
   assign data_out0  = regs[0];
   assign data_out1  = regs[1];
   assign data_out2  = regs[2];
   assign data_out3  = regs[3];
   assign data_out4  = regs[4];
   assign data_out5  = regs[5];
   assign data_out6  = regs[6];
   assign data_out7  = regs[7];
   assign data_out8  = regs[8];
   assign data_out9  = regs[9];
   assign data_out10 = regs[10];
   assign data_out11 = regs[11];
   assign data_out12 = regs[12];
   assign data_out13 = regs[13];
   assign data_out14 = regs[14];
   assign data_out15 = regs[15];

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed scoreboard bench for register_bank
module tb_register_bank;

   logic        clk;
   logic        reset_n;
   logic        write_en;
   logic [3:0]  write_addr;
   logic [15:0] write_data;
   logic        clear_req;
   logic [15:0] dout [16];
   logic        busy;
   logic        write_drop;

   typedef struct {
      string       tag;
      int          idx;
      logic [15:0] exp;
   } item_t;

   item_t       q[$];
   logic [15:0] m [16];
   logic        m_busy;
   logic        m_drop;
   int          checks;
   int          failures;

   register_bank #(.WIDTH(16), .CLEAR_VALUE(16'h0000)) dut (
      .clk(clk), .reset_n(reset_n), .write_en(write_en), .write_addr(write_addr),
      .write_data(write_data), .clear_req(clear_req),
      .data_out0(dout[0]),   .data_out1(dout[1]),   .data_out2(dout[2]),   .data_out3(dout[3]),
      .data_out4(dout[4]),   .data_out5(dout[5]),   .data_out6(dout[6]),   .data_out7(dout[7]),
      .data_out8(dout[8]),   .data_out9(dout[9]),   .data_out10(dout[10]), .data_out11(dout[11]),
      .data_out12(dout[12]), .data_out13(dout[13]), .data_out14(dout[14]), .data_out15(dout[15]),
      .busy(busy), .write_drop(write_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] observe(input int idx);
      if (idx < 16)  return dout[idx];
      if (idx == 16) return {15'd0, busy};
      return {15'd0, write_drop};
   endfunction

   // Expected values go in when the step is driven, come out once the DUT has responded
   task automatic push_expect(input string tag);
      for (int i = 0; i < 16; i++) q.push_back('{tag, i, m[i]});
      q.push_back('{tag, 16, {15'd0, m_busy}});
      q.push_back('{tag, 17, {15'd0, m_drop}});
   endtask

   task automatic drain(input string tag);
      item_t       it;
      logic [15:0] obs;
      push_expect(tag);
      while (q.size() > 0) begin
         it  = q.pop_front();
         obs = observe(it.idx);
         checks++;
         assert (obs === it.exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h", it.tag, it.idx, obs, it.exp);
         end
      end
   endtask

   task automatic cycle(input logic we, input logic [3:0] a, input logic [15:0] d, input logic cr);
      write_en   = we;
      write_addr = a;
      write_data = d;
      clear_req  = cr;
      @(posedge clk);
      #1;
      write_en  = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic fill();
      for (int n = 0; n < 16; n++) begin
         cycle(1'b1, 4'(n), 16'(n * 16'h1111), 1'b0);
         m[n]   = 16'(n * 16'h1111);
         m_drop = 1'b0;
         drain($sformatf("fill_r%0d", n));
      end
   endtask

   task automatic run_clear(input string tag, input logic we0, input logic [3:0] wa,
                            input logic [15:0] wd, input int drop_k, input int drop_n,
                            input logic [3:0] drop_a, input int creq_k, input int abort_k);
      logic in_drop;
      cycle(we0, wa, wd, 1'b1);
      if (we0) m[wa] = wd;
      m_busy = 1'b1;
      m_drop = 1'b0;
      drain({tag, "_start"});
      for (int k = 0; k < 16; k++) begin
         if (k == abort_k) begin
            reset_n = 1'b0;
            #2;
            for (int i = 0; i < 16; i++) m[i] = 16'h0000;
            m_busy = 1'b0;
            m_drop = 1'b0;
            drain({tag, "_abort"});
            #2;
            reset_n = 1'b1;
            return;
         end
         in_drop = (k >= drop_k) && (k < drop_k + drop_n);
         cycle(in_drop, drop_a, 16'hAAAA, k == creq_k);
         m[k]   = 16'h0000;
         m_busy = (k != 15);
         m_drop = in_drop;
         drain($sformatf("%s_k%0d", tag, k));
      end
      cycle(1'b0, 4'd0, 16'h0000, 1'b0);
      m_drop = 1'b0;
      drain({tag, "_after"});
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      write_en   = 1'b0;
      write_addr = 4'd0;
      write_data = 16'h0000;
      clear_req  = 1'b0;
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
      m_busy = 1'b0;
      m_drop = 1'b0;

      #12;
      drain("reset");
      @(negedge clk);
      reset_n = 1'b1;

      cycle(1'b1, 4'd3, 16'h1234, 1'b0);
      m[3] = 16'h1234;
      drain("wr_r3");
      cycle(1'b1, 4'd15, 16'hBEEF, 1'b0);
      m[15] = 16'hBEEF;
      drain("wr_r15");

      fill();
      run_clear("clr_plain", 1'b0, 4'd0, 16'h0000, -1, 0, 4'd0, -1, -1);

      fill();
      run_clear("clr_drop", 1'b0, 4'd0, 16'h0000, 5, 1, 4'd2, -1, -1);

      fill();
      run_clear("clr_b2b", 1'b0, 4'd0, 16'h0000, 7, 2, 4'd12, 10, -1);

      fill();
      run_clear("clr_wr", 1'b1, 4'd7, 16'h5555, -1, 0, 4'd0, -1, -1);

      fill();
      run_clear("clr_abort", 1'b0, 4'd0, 16'h0000, -1, 0, 4'd0, -1, 6);
      cycle(1'b1, 4'd9, 16'h9999, 1'b0);
      m[9] = 16'h9999;
      drain("post_abort_wr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
